// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, funct3 size codes,
// FSM state encoding and the access-size decode used by store lanes and
// misalignment detection.
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // Access size from direction and funct3; unlisted codes fall back to word.
    function automatic lsu_size_e access_size(input logic we, input logic [2:0] f3);
        lsu_size_e sz;
        sz = SZ_WORD;
        if (we) begin
            if (f3 == F3_B)      sz = SZ_BYTE;
            else if (f3 == F3_H) sz = SZ_HALF;
        end else begin
            if ((f3 == F3_B) || (f3 == F3_BU))      sz = SZ_BYTE;
            else if ((f3 == F3_H) || (f3 == F3_HU)) sz = SZ_HALF;
        end
        return sz;
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter: selects the addressed byte/half of the returned word
// and sign- or zero-extends it according to funct3.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = i_rdata;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h000000, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0000, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one single-beat data-memory transaction at a time with a
// REQ/WAIT timeout. Optional macro LSU_MISALIGN_TRAP_EN turns misaligned
// half/word accesses into an immediate completion with misalign_o set
// instead of issuing a bus request.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned WAIT_MAX = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] load_out,
    output logic            bus_err_o,
    output logic            misalign_o,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_e      r_state;
    lsu_state_e      w_next;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_accept;
    logic            w_busy;
    logic            w_timeout;
    logic            w_err_exit;
    logic            w_misalign;
    lsu_size_e       w_size;
    logic [XLEN-1:0] w_wdata;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_fmt;

    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_load_out;
    logic            r_bus_err;

    assign w_is_load  = (opcode == OPC_LOAD);
    assign w_is_store = (opcode == OPC_STORE);
    assign w_accept   = (r_state == ST_IDLE) && valid_i && (w_is_load || w_is_store);
    assign w_timeout  = (r_cnt == CNT_W'(WAIT_MAX - 1));
    assign w_size     = access_size(w_is_store, funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == SZ_HALF) && alu_out[0]) ||
                        ((w_size == SZ_WORD) && (alu_out[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Store lane generation from the incoming address and data.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = rs2_data;
        case (w_size)
            SZ_BYTE: begin
                w_wstrb = 4'b0001 << alu_out[1:0];
                w_wdata = {4{rs2_data[7:0]}};
            end
            SZ_HALF: begin
                w_wstrb = 4'b0011 << {alu_out[1], 1'b0};
                w_wdata = {2{rs2_data[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = rs2_data;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state, stall request and timeout-exit decode.
    always_comb begin
        w_next     = r_state;
        w_busy     = 1'b0;
        w_err_exit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_busy = 1'b1;
                    w_next = w_misalign ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                w_busy = 1'b1;
                if (mem_gnt) begin
                    w_next = r_we ? ST_DONE : ST_WAIT;
                end else if (w_timeout) begin
                    w_next     = ST_DONE;
                    w_err_exit = 1'b1;
                end
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (mem_rvalid) begin
                    w_next = ST_DONE;
                end else if (w_timeout) begin
                    w_next     = ST_DONE;
                    w_err_exit = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, timeout counter, load result and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= 4'b0000;
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_cnt      <= '0;
            r_load_out <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= alu_out;
                r_we     <= w_is_store;
                r_funct3 <= funct3;
                r_wdata  <= w_is_store ? w_wdata : '0;
                r_wstrb  <= w_is_store ? w_wstrb : 4'b0000;
                r_cnt    <= '0;
            end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == ST_WAIT) && mem_rvalid) begin
                r_load_out <= w_fmt;
            end
            r_bus_err <= w_err_exit;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misalign;

    // Misalignment flag, set on the accept that skips the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_misalign <= 1'b0;
        else        r_misalign <= w_accept && w_misalign;
    end

    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

    lsu_load_fmt u_load_fmt (
        .i_rdata   (mem_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_data    (w_fmt)
    );

    assign busy_o    = w_busy;
    assign done_o    = (r_state == ST_DONE);
    assign bus_err_o = r_bus_err;
    assign load_out  = r_load_out;
    assign mem_req   = (r_state == ST_REQ);
    assign mem_we    = r_we;
    assign mem_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases followed by random accesses,
// checked against a byte-arithmetic reference model. WAIT_MAX is reduced to 8.
module tb_lsu;

    localparam int WMAX = 8;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic        busy_o;
    logic        done_o;
    logic [31:0] load_out;
    logic        bus_err_o;
    logic        misalign_o;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          total;
    int          bad;
    logic [31:0] exp_load;

    lsu #(.XLEN(32), .WAIT_MAX(WMAX), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .opcode     (opcode),
        .funct3     (funct3),
        .alu_out    (alu_out),
        .rs2_data   (rs2_data),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .load_out   (load_out),
        .bus_err_o  (bus_err_o),
        .misalign_o (misalign_o),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Access width in bytes from direction and funct3.
    function automatic int nbytes(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [3:0] ref_strb(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int n;
        int off;
        n   = nbytes(we, f3);
        off = int'(a[1:0]);
        if (!we)    return 4'h0;
        if (n == 1) return 4'(1 << off);
        if (n == 2) return 4'(3 << (off & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n;
        n = nbytes(1'b1, f3);
        if (n == 1) return (d & 32'hFF) * 32'h01010101;
        if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int          n;
        int          off;
        logic [31:0] v;
        n   = nbytes(1'b0, f3);
        off = int'(a[1:0]);
        if (n == 1) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
            return v;
        end
        if (n == 2) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
            return v;
        end
        return rd;
    endfunction

    function automatic logic is_misaligned(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(we, f3);
        return ((n == 2) && (a[0] == 1'b1)) || ((n == 4) && (a[1:0] != 2'b00));
    endfunction

    // One complete access, starting and ending at a falling edge in IDLE.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sdata, input logic [31:0] rd,
                          input int gdly, input int rdly);
        logic trap;
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = is_misaligned(we, f3, a);
`endif
        valid_i  = 1'b1;
        opcode   = we ? 7'b0100011 : 7'b0000011;
        funct3   = f3;
        alu_out  = a;
        rs2_data = sdata;
        #1;
        chk1("busy_accept", busy_o, 1'b1);
        @(posedge clk); @(negedge clk);
        valid_i  = 1'b0;
        opcode   = 7'($urandom);
        alu_out  = $urandom;
        rs2_data = $urandom;
        if (trap) begin
            chk1("trap_no_req", mem_req, 1'b0);
            chk1("trap_done", done_o, 1'b1);
            chk1("trap_misalign", misalign_o, 1'b1);
            chk32("trap_load_kept", load_out, exp_load);
        end else begin
            for (int i = 0; i <= gdly; i++) begin
                chk1("req_high", mem_req, 1'b1);
                chk1("req_busy", busy_o, 1'b1);
                chk1("req_no_done", done_o, 1'b0);
                chk32("req_addr", mem_addr, {a[31:2], 2'b00});
                chk1("req_we", mem_we, we);
                chk32("req_wstrb", 32'(mem_wstrb), 32'(ref_strb(we, f3, a)));
                if (we) chk32("req_wdata", mem_wdata, ref_wdata(f3, sdata));
                mem_gnt = (i == gdly);
                @(posedge clk); @(negedge clk);
            end
            mem_gnt = 1'b0;
            if (!we) begin
                for (int i = 1; i <= rdly; i++) begin
                    chk1("wait_req_low", mem_req, 1'b0);
                    chk1("wait_busy", busy_o, 1'b1);
                    chk1("wait_no_done", done_o, 1'b0);
                    mem_rvalid = (i == rdly);
                    mem_rdata  = (i == rdly) ? rd : $urandom;
                    @(posedge clk); @(negedge clk);
                end
                mem_rvalid = 1'b0;
                exp_load   = ref_load(f3, a, rd);
            end
            chk1("done_pulse", done_o, 1'b1);
            chk1("done_busy_low", busy_o, 1'b0);
            chk1("done_bus_err", bus_err_o, 1'b0);
            chk1("done_misalign", misalign_o, 1'b0);
            chk32("done_load_out", load_out, exp_load);
        end
        // stray rvalid outside WAIT must be ignored
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        @(posedge clk); @(negedge clk);
        mem_rvalid = 1'b0;
        chk1("idle_done_low", done_o, 1'b0);
        chk1("idle_req_low", mem_req, 1'b0);
        chk1("idle_busy_low", busy_o, 1'b0);
        chk32("idle_load_kept", load_out, exp_load);
    endtask

    // Aligned LW whose data never returns; grant given at REQ cycle gcyc (0 = never).
    task automatic do_timeout(input int gcyc);
        valid_i = 1'b1;
        opcode  = 7'b0000011;
        funct3  = 3'd2;
        alu_out = 32'h0000_0400;
        @(posedge clk); @(negedge clk);
        valid_i = 1'b0;
        for (int i = 1; i <= WMAX; i++) begin
            chk1("to_no_done", done_o, 1'b0);
            chk1("to_busy", busy_o, 1'b1);
            chk1("to_req", mem_req, (gcyc == 0) || (i <= gcyc));
            mem_gnt = (i == gcyc);
            @(posedge clk); @(negedge clk);
        end
        mem_gnt = 1'b0;
        chk1("to_done", done_o, 1'b1);
        chk1("to_bus_err", bus_err_o, 1'b1);
        chk1("to_req_dropped", mem_req, 1'b0);
        chk32("to_load_kept", load_out, exp_load);
        @(posedge clk); @(negedge clk);
        chk1("to_done_once", done_o, 1'b0);
        chk1("to_err_clear", bus_err_o, 1'b0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        exp_load   = 32'h0;
        rst_n      = 1'b0;
        valid_i    = 1'b0;
        opcode     = 7'h00;
        funct3     = 3'd0;
        alu_out    = 32'h0;
        rs2_data   = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // reset state
        @(negedge clk); @(negedge clk);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_req", mem_req, 1'b0);
        chk32("rst_load_out", load_out, 32'h0);
        chk32("rst_addr", mem_addr, 32'h0);
        chk1("rst_bus_err", bus_err_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // non-memory opcode is ignored
        valid_i = 1'b1;
        opcode  = 7'b0110011;
        #1;
        chk1("nonmem_busy", busy_o, 1'b0);
        @(posedge clk); @(negedge clk);
        chk1("nonmem_req", mem_req, 1'b0);
        chk1("nonmem_done", done_o, 1'b0);
        valid_i = 1'b0;

        // plan cases
        do_txn(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2, 1);
        do_txn(1'b0, 3'd0, 32'h0000_0203, 32'h0, 32'h80FF_0000, 0, 1);
        chk32("lb_value", load_out, 32'hFFFF_FF80);
        do_txn(1'b0, 3'd4, 32'h0000_0203, 32'h0, 32'h80FF_0000, 1, 2);
        chk32("lbu_value", load_out, 32'h0000_0080);
        do_txn(1'b0, 3'd1, 32'h0000_0302, 32'h0, 32'h8001_1234, 0, 3);
        chk32("lh_value", load_out, 32'hFFFF_8001);
        do_txn(1'b1, 3'd1, 32'h0000_0302, 32'h0000_ABCD, 32'h0, 1, 1);
        do_txn(1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h1357_9BDF, 0, 1);

        // timeouts: granted then no data, and never granted
        do_timeout(2);
        do_timeout(0);

        // valid held through DONE is accepted only in the following IDLE
        valid_i  = 1'b1;
        opcode   = 7'b0100011;
        funct3   = 3'd2;
        alu_out  = 32'h0000_0600;
        rs2_data = 32'h0BAD_F00D;
        @(posedge clk); @(negedge clk);
        mem_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_gnt = 1'b0;
        chk1("b2b_done", done_o, 1'b1);
        chk1("b2b_done_busy", busy_o, 1'b0);
        @(posedge clk); @(negedge clk);
        chk1("b2b_idle_req", mem_req, 1'b0);
        chk1("b2b_idle_done", done_o, 1'b0);
        chk1("b2b_idle_busy", busy_o, 1'b1);
        @(posedge clk); @(negedge clk);
        valid_i = 1'b0;
        chk1("b2b_req", mem_req, 1'b1);
        chk32("b2b_addr", mem_addr, 32'h0000_0600);
        mem_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_gnt = 1'b0;
        chk1("b2b_done2", done_o, 1'b1);
        @(posedge clk); @(negedge clk);

        // reset in WAIT, then a late rvalid
        valid_i = 1'b1;
        opcode  = 7'b0000011;
        funct3  = 3'd2;
        alu_out = 32'h0000_0500;
        @(posedge clk); @(negedge clk);
        valid_i = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_gnt = 1'b0;
        chk1("pre_rst_wait_busy", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_busy", busy_o, 1'b0);
        chk1("mid_rst_req", mem_req, 1'b0);
        chk1("mid_rst_done", done_o, 1'b0);
        chk1("mid_rst_we", mem_we, 1'b0);
        chk32("mid_rst_addr", mem_addr, 32'h0);
        chk32("mid_rst_load_out", load_out, 32'h0);
        exp_load = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h1234_5678;
            @(posedge clk); @(negedge clk);
            chk1("late_rvalid_done", done_o, 1'b0);
            chk32("late_rvalid_load", load_out, 32'h0);
        end
        mem_rvalid = 1'b0;
        do_txn(1'b0, 3'd2, 32'h0000_0700, 32'h0, 32'hCAFE_0001, 1, 1);
        chk32("post_rst_lw", load_out, 32'hCAFE_0001);

        // random accesses
        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting between execute and writeback.
- Accepts one memory instruction at a time, issues a single-beat request on the data-memory bus, and formats returned data by funct3.
- Produces `load_out` for the writeback stage and stalls the pipeline with `busy_o` while a transaction is in flight.
- Non-memory opcodes are ignored.

Parameters:
- XLEN, 32: datapath/address width; only 32 supported.
- WAIT_MAX, 255: bus timeout in cycles, counted across REQ+WAIT; must be >= 2.
- CNT_W, 8: timeout counter width; must hold WAIT_MAX.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  execute stage presents an instruction.
- opcode  in  7  instruction opcode.
- funct3  in  3  access size/sign.
- alu_out  in  32  effective address.
- rs2_data  in  32  store data.
- busy_o  out  1  stall request to pipeline.
- done_o  out  1  one-cycle completion pulse.
- load_out  out  32  formatted load result, held until the next load completes.
- bus_err_o  out  1  timeout flag, valid with done_o.
- misalign_o  out  1  misalignment flag, valid with done_o.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
- Reset: state IDLE, all outputs 0, load_out 0, timeout counter 0.
- Memory ops: load opcode 0000011, store opcode 0100011. Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store funct3: 000 SB, 001 SH, 010 SW. Other funct3 values are treated as word access.
- IDLE:
  - busy_o = valid_i & is_mem (combinational).
  - On a clock edge with that true: latch addr, data, funct3, we; clear counter; go to REQ.
- REQ:
  - mem_req=1 with stable addr/we/wdata/wstrb until mem_gnt.
  - On gnt: store goes to DONE; load goes to WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: load_out <= formatted data; go to DONE.
  - mem_rvalid is ignored in any state other than WAIT.
  - rvalid arrives no earlier than the cycle after gnt.
- DONE:
  - done_o=1 and busy_o=0 for exactly one cycle, then IDLE.
  - A new valid_i is not accepted in DONE; the earliest accept is in the following IDLE cycle.
- Timeout:
  - Counter increments every cycle in REQ/WAIT.
  - When the count reaches WAIT_MAX-1 without progress: drop mem_req, go to DONE with bus_err_o=1, load_out unchanged.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0], wdata = byte x4.
  - SH: wstrb = 0011<<{addr[1],0}, wdata = half x2.
  - SW: wstrb = 1111.
  - Loads drive wstrb = 0000.
- Load format:
  - Byte selected by addr[1:0]; half selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is the full word.
- Reset mid-transaction: immediate return to IDLE with mem_req=0. A grant or rvalid that arrives after reset is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- Defined: a misaligned accept goes IDLE→DONE directly, with no bus request. misalign_o=1 with done_o, and load_out is unchanged.
- Undefined: misalign_o is tied to 0. The access proceeds with the offending low address bits ignored (half uses addr[1]; word uses aligned word).

Decomposition:
- Shared define file holds:
  - opcode constants (load, store);
  - funct3 size codes;
  - FSM state encoding (IDLE, REQ, WAIT, DONE).
- One combinational sub-module, lsu_load_fmt: inputs rdata, addr[1:0], funct3; output the 32-bit extended result.
- Store lane generation stays inline.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt after 2 cycles: mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF. done_o pulses one cycle after gnt. busy_o is high from accept until done.
- LB addr 0x203, rdata 0x80FF_0000 → load_out=0xFFFFFF80. Same access with LBU → load_out=0x00000080.
- LH addr 0x302, rdata 0x8001_1234 → load_out=0xFFFF8001. SH of data 0x0000ABCD to the same address → wstrb=1100, wdata=0xABCDABCD.
- Load, gnt given, rvalid never arrives, WAIT_MAX=8: done_o asserts with bus_err_o=1 once the timeout counter reaches WAIT_MAX-1 (eighth cycle of REQ/WAIT). load_out retains its previous value.
- Reset asserted while in WAIT, then a late rvalid: outputs are all 0 and no done_o occurs. A new LW is then accepted normally.
- With LSU_MISALIGN_TRAP_EN, LW addr 0x101: no mem_req, done_o with misalign_o=1 one cycle after accept. Without the macro: mem_addr=0x100, and the access completes with misalign_o=0.
